// File: rtl/game_ctrl_pkg.sv
// Shared types for the snake game sequencer: game state encoding.
// Pure declarations; no logic, no latency.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/game_ctrl_step_divider.sv
// Divides base ticks into step pulses of 'period' ticks; tick -> step 1 cycle.
// No backpressure: ticks are counted only while en is high, clear wins over en.
module game_ctrl_step_divider #(
  parameter int PERIOD_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clear,
  input  logic                tick,
  input  logic [PERIOD_W-1:0] period,
  output logic                step
);

  logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
  logic                step_q, step_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    step_d     = 1'b0;
    if (clear) begin
      tick_cnt_d = '0;
    end else if (en && tick) begin
      // >= so a period that just shrank below the running count steps on the next tick
      if (tick_cnt_q >= period - PERIOD_W'(1)) begin
        tick_cnt_d = '0;
        step_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      step_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      step_q     <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/game_ctrl.sv
// Snake game sequencer: state machine, step pacing, score and session high score.
// All outputs registered; every event reacts 1 cycle later. No backpressure.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int PERIOD_W      = 4,
  parameter int SPEED_INIT    = 8,
  parameter int SPEED_MIN     = 2,
  parameter int SPEEDUP_EVERY = 4,
  parameter int SCORE_W       = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                start,
  input  logic                pause,
  input  logic                collision,
  input  logic                food_eaten,
  output logic                field_init,
  output logic                step,
  output logic [1:0]          state,
  output logic [PERIOD_W-1:0] period,
  output logic [SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]  hi_score
);

  localparam int EAT_W = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;

  state_e              state_q, state_d;
  logic                field_init_q, field_init_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  hi_score_q, hi_score_d;
  logic [EAT_W-1:0]    eat_cnt_q, eat_cnt_d;
  logic                div_en, div_clear;

  always_comb begin
    state_d      = state_q;
    field_init_d = 1'b0;
    period_d     = period_q;
    score_d      = score_q;
    hi_score_d   = hi_score_q;
    eat_cnt_d    = eat_cnt_q;
    div_en       = 1'b0;
    div_clear    = 1'b0;
    if (start) begin
      state_d      = ST_RUN;
      field_init_d = 1'b1;
      period_d     = PERIOD_W'(SPEED_INIT);
      score_d      = '0;
      eat_cnt_d    = '0;
      div_clear    = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (collision) begin
            state_d = ST_OVER;
            if (score_q > hi_score_q) hi_score_d = score_q;
          end else if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            div_en = 1'b1;
            if (food_eaten) begin
              if (score_q != '1) score_d = score_q + SCORE_W'(1);
              if (eat_cnt_q == EAT_W'(SPEEDUP_EVERY - 1)) begin
                eat_cnt_d = '0;
                if (period_q > PERIOD_W'(SPEED_MIN)) period_d = period_q - PERIOD_W'(1);
              end else begin
                eat_cnt_d = eat_cnt_q + EAT_W'(1);
              end
            end
          end
        end
        ST_PAUSE: if (pause) state_d = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      field_init_q <= 1'b0;
      period_q     <= PERIOD_W'(SPEED_INIT);
      score_q      <= '0;
      hi_score_q   <= '0;
      eat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      field_init_q <= field_init_d;
      period_q     <= period_d;
      score_q      <= score_d;
      hi_score_q   <= hi_score_d;
      eat_cnt_q    <= eat_cnt_d;
    end
  end

  game_ctrl_step_divider #(.PERIOD_W(PERIOD_W)) u_step_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .clear (div_clear),
    .tick  (tick),
    .period(period_q),
    .step  (step)
  );

  assign field_init = field_init_q;
  assign state      = state_q;
  assign period     = period_q;
  assign score      = score_q;
  assign hi_score   = hi_score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: default instance plus a SCORE_W=3 instance for saturation.
module tb_game_ctrl;

  logic clk = 1'b0;
  logic rst_n, tick, start, pause, collision, food_eaten;
  logic start3, food3;
  logic       field_init, step;
  logic [1:0] state;
  logic [3:0] period;
  logic [9:0] score, hi_score;
  logic       field_init3, step3;
  logic [1:0] state3;
  logic [3:0] period3;
  logic [2:0] score3, hi_score3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  game_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause),
    .collision(collision), .food_eaten(food_eaten), .field_init(field_init),
    .step(step), .state(state), .period(period), .score(score), .hi_score(hi_score)
  );

  game_ctrl #(.SCORE_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tick(1'b0), .start(start3), .pause(1'b0),
    .collision(1'b0), .food_eaten(food3), .field_init(field_init3),
    .step(step3), .state(state3), .period(period3), .score(score3), .hi_score(hi_score3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle pulse; returns at the following falling edge, where the response is visible.
  task automatic pulse(input int sel);
    @(negedge clk);
    case (sel)
      0: start = 1'b1;
      1: pause = 1'b1;
      2: collision = 1'b1;
      3: food_eaten = 1'b1;
      4: tick = 1'b1;
      5: begin collision = 1'b1; food_eaten = 1'b1; end
      6: begin start = 1'b1; pause = 1'b1; end
      7: start3 = 1'b1;
      8: food3 = 1'b1;
      default: ;
    endcase
    @(negedge clk);
    {start, pause, collision, food_eaten, tick, start3, food3} = '0;
  endtask

  // n ticks spaced 10 clocks apart; counts step pulses seen one cycle after each tick.
  task automatic do_ticks(input int n, output int steps, output int last);
    steps = 0;
    last  = 0;
    for (int i = 0; i < n; i++) begin
      pulse(4);
      last  = int'(step);
      steps += last;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, l;
    {start, pause, collision, food_eaten, tick, start3, food3} = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_period", period, 8);
    chk("rst_score", score, 0);
    chk("rst_hi", hi_score, 0);
    chk("rst_fi", field_init, 0);
    chk("rst_step", step, 0);

    // start, step every 8th tick
    pulse(0);
    chk("t1_fi", field_init, 1);
    chk("t1_state", state, 1);
    chk("t1_period", period, 8);
    chk("t1_step_at_fi", step, 0);
    do_ticks(7, s, l);
    chk("t1_no_step_7", s, 0);
    do_ticks(1, s, l);
    chk("t1_step_8th", l, 1);
    chk("t1_fi_once", field_init, 0);
    do_ticks(8, s, l);
    chk("t1_steps_16", s, 1);
    chk("t1_step_16th", l, 1);

    // pause mid-interval holds the partial count
    do_ticks(5, s, l);
    chk("t3_pre_pause", s, 0);
    pulse(1);
    chk("t3_paused", state, 2);
    do_ticks(20, s, l);
    chk("t3_no_step_paused", s, 0);
    pulse(1);
    chk("t3_resumed", state, 1);
    do_ticks(2, s, l);
    chk("t3_resume_2", s, 0);
    do_ticks(1, s, l);
    chk("t3_resume_3rd", l, 1);

    // collision beats food; hi_score latched
    pulse(0);
    repeat (3) pulse(3);
    chk("t4_score3", score, 3);
    pulse(5);
    chk("t4_over", state, 3);
    chk("t4_score_kept", score, 3);
    chk("t4_hi", hi_score, 3);
    do_ticks(8, s, l);
    chk("t4_no_step_over", s, 0);
    pulse(0);
    chk("t4_restart_score", score, 0);
    chk("t4_restart_hi", hi_score, 3);
    chk("t4_restart_fi", field_init, 1);
    chk("t4_restart_state", state, 1);

    // speed-up and floor
    repeat (4) pulse(3);
    chk("t2_score4", score, 4);
    chk("t2_period7", period, 7);
    repeat (24) pulse(3);
    chk("t2_score28", score, 28);
    chk("t2_period_floor", period, 2);
    do_ticks(1, s, l);
    chk("t2_p2_tick1", l, 0);
    do_ticks(1, s, l);
    chk("t2_p2_tick2", l, 1);

    // start and pause together from PAUSE, then async reset mid-game
    pulse(1);
    chk("t5_paused", state, 2);
    pulse(6);
    chk("t5_restart_state", state, 1);
    chk("t5_restart_fi", field_init, 1);
    chk("t5_restart_period", period, 8);
    chk("t5_restart_score", score, 0);
    pulse(3);
    chk("t5_score1", score, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_arst_state", state, 0);
    chk("t5_arst_score", score, 0);
    chk("t5_arst_hi", hi_score, 0);
    chk("t5_arst_period", period, 8);
    chk("t5_arst_fi", field_init, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_post_state", state, 0);

    // narrow score saturates
    pulse(7);
    chk("t6_state", state3, 1);
    repeat (9) pulse(8);
    chk("t6_score_sat", score3, 7);
    chk("t6_period", period3, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
